// File: rtl/ring_ctrl.sv
// ring_ctrl: buzzer request controller for an alarm clock.
// Decides between silence, the hourly chime, the alarm and snooze.
// Triggers are evaluated once per second on tick_1hz. Outputs are
// registered and decoded from the next state.
module ring_ctrl #(
  parameter int CHIME_SEC  = 3,
  parameter int ALARM_SEC  = 10,
  parameter int SNOOZE_SEC = 5,
  parameter int SNOOZE_MAX = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       chime_en,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic [1:0] ring,
  output logic       snoozing
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHIME  = 2'd1,
    ALARM  = 2'd2,
    SNOOZE = 2'd3
  } state_t;

  localparam logic [7:0] CHIME_LIM  = 8'(CHIME_SEC);
  localparam logic [7:0] ALARM_LIM  = 8'(ALARM_SEC);
  localparam logic [7:0] SNOOZE_LIM = 8'(SNOOZE_SEC);
  localparam logic [2:0] SNZ_MAX    = 3'(SNOOZE_MAX);

  state_t     state;
  logic [7:0] sec_cnt;
  logic [2:0] snooze_cnt;
  logic [7:0] sec_cnt_inc;
  logic       alarm_hit;
  logic       chime_hit;

  // Trigger conditions are only acted on in tick cycles.
  assign alarm_hit   = alarm_en && (cur_hour == alarm_hour) &&
                       (cur_min == alarm_min) && (cur_sec == 6'd0);
  assign chime_hit   = chime_en && (cur_min == 6'd0) && (cur_sec == 6'd0);
  assign sec_cnt_inc = sec_cnt + 8'd1;

  // Output decode: {ring[1:0], snoozing} for a given state.
  function automatic logic [2:0] out_dec(input state_t s);
    case (s)
      CHIME:   out_dec = 3'b010;
      ALARM:   out_dec = 3'b100;
      SNOOZE:  out_dec = 3'b001;
      default: out_dec = 3'b000;
    endcase
  endfunction

  // Main FSM: state, seconds counter, snooze count and registered outputs.
  // Every state entry clears the seconds counter; IDLE entry also clears
  // the snooze count so each alarm event gets a fresh snooze allowance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      sec_cnt          <= 8'd0;
      snooze_cnt       <= 3'd0;
      {ring, snoozing} <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          snooze_cnt <= 3'd0;
          if (tick_1hz && alarm_hit) begin
            state            <= ALARM;
            sec_cnt          <= 8'd0;
            {ring, snoozing} <= out_dec(ALARM);
          end else if (tick_1hz && chime_hit) begin
            state            <= CHIME;
            sec_cnt          <= 8'd0;
            {ring, snoozing} <= out_dec(CHIME);
          end
        end

        CHIME: begin
          // An alarm pre-empts the chime and restarts the count.
          if (tick_1hz && alarm_hit) begin
            state            <= ALARM;
            sec_cnt          <= 8'd0;
            {ring, snoozing} <= out_dec(ALARM);
          end else if (tick_1hz && (sec_cnt_inc == CHIME_LIM)) begin
            state            <= IDLE;
            sec_cnt          <= 8'd0;
            snooze_cnt       <= 3'd0;
            {ring, snoozing} <= out_dec(IDLE);
          end else if (tick_1hz) begin
            sec_cnt <= sec_cnt_inc;
          end
        end

        ALARM: begin
          // Priority: disarm, stop, expiry, then snooze.
          if (!alarm_en || stop_btn ||
              (tick_1hz && (sec_cnt_inc == ALARM_LIM))) begin
            state            <= IDLE;
            sec_cnt          <= 8'd0;
            snooze_cnt       <= 3'd0;
            {ring, snoozing} <= out_dec(IDLE);
          end else if (snooze_btn && (snooze_cnt < SNZ_MAX)) begin
            state            <= SNOOZE;
            sec_cnt          <= 8'd0;
            snooze_cnt       <= snooze_cnt + 3'd1;
            {ring, snoozing} <= out_dec(SNOOZE);
          end else if (tick_1hz) begin
            sec_cnt <= sec_cnt_inc;
          end
        end

        SNOOZE: begin
          if (!alarm_en || stop_btn) begin
            state            <= IDLE;
            sec_cnt          <= 8'd0;
            snooze_cnt       <= 3'd0;
            {ring, snoozing} <= out_dec(IDLE);
          end else if (tick_1hz && (sec_cnt_inc == SNOOZE_LIM)) begin
            state            <= ALARM;
            sec_cnt          <= 8'd0;
            {ring, snoozing} <= out_dec(ALARM);
          end else if (tick_1hz) begin
            sec_cnt <= sec_cnt_inc;
          end
        end

        default: begin
          state            <= IDLE;
          sec_cnt          <= 8'd0;
          snooze_cnt       <= 3'd0;
          {ring, snoozing} <= out_dec(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_ctrl.sv
// tb_ring_ctrl: directed bench for ring_ctrl with default parameters
// (chime 3 s, alarm 10 s, snooze 5 s, two snoozes allowed).
// Outputs are compared as {ring, snoozing} one time unit after clk rises.
module tb_ring_ctrl;

  localparam logic [2:0] O_IDLE  = 3'b000;
  localparam logic [2:0] O_CHIME = 3'b010;
  localparam logic [2:0] O_ALARM = 3'b100;
  localparam logic [2:0] O_SNZ   = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       alarm_en;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       chime_en;
  logic       stop_btn;
  logic       snooze_btn;
  logic [1:0] ring;
  logic       snoozing;

  int errors = 0;
  int checks = 0;

  ring_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .alarm_en   (alarm_en),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .chime_en   (chime_en),
    .stop_btn   (stop_btn),
    .snooze_btn (snooze_btn),
    .ring       (ring),
    .snoozing   (snoozing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: {ring,snoozing} got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hour = 5'(h);
    cur_min  = 6'(m);
    cur_sec  = 6'(s);
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      do_tick();
    end
  endtask

  task automatic press_stop();
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    tick_1hz   = 1'b0;
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    alarm_en   = 1'b0;
    chime_en   = 1'b0;
    alarm_hour = 5'd7;
    alarm_min  = 6'd30;
    set_time(0, 0, 1);
    #12;
    check("reset", {ring, snoozing}, O_IDLE);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("after_reset", {ring, snoozing}, O_IDLE);

    // Buttons in IDLE have no effect
    press_snooze();
    check("idle_snooze_ign", {ring, snoozing}, O_IDLE);

    // Hourly chime at 14:00:00, ends on 3rd following tick
    chime_en = 1'b1;
    set_time(14, 0, 0);
    do_tick();
    check("chime_start", {ring, snoozing}, O_CHIME);
    set_time(14, 0, 1);
    press_stop();
    check("chime_stop_ign", {ring, snoozing}, O_CHIME);
    ticks(2);
    check("chime_2ticks", {ring, snoozing}, O_CHIME);
    ticks(1);
    check("chime_end", {ring, snoozing}, O_IDLE);

    // Alarm 07:30 with stop after 4 ticks
    alarm_en = 1'b1;
    set_time(7, 30, 0);
    do_tick();
    check("alarm_start", {ring, snoozing}, O_ALARM);
    set_time(7, 30, 1);
    ticks(4);
    check("alarm_4ticks", {ring, snoozing}, O_ALARM);
    press_stop();
    check("alarm_stop", {ring, snoozing}, O_IDLE);
    set_time(7, 30, 5);
    ticks(1);
    check("no_chime_min30", {ring, snoozing}, O_IDLE);

    // Snooze limit
    set_time(7, 30, 0);
    do_tick();
    check("snz_alarm", {ring, snoozing}, O_ALARM);
    set_time(7, 30, 1);
    press_snooze();
    check("snz1_enter", {ring, snoozing}, O_SNZ);
    ticks(4);
    check("snz1_4ticks", {ring, snoozing}, O_SNZ);
    ticks(1);
    check("snz1_back", {ring, snoozing}, O_ALARM);
    press_snooze();
    check("snz2_enter", {ring, snoozing}, O_SNZ);
    ticks(5);
    check("snz2_back", {ring, snoozing}, O_ALARM);
    press_snooze();
    check("snz3_ignored", {ring, snoozing}, O_ALARM);
    ticks(9);
    check("alarm_9ticks", {ring, snoozing}, O_ALARM);
    ticks(1);
    check("alarm_expire", {ring, snoozing}, O_IDLE);

    // Alarm and chime coincide at 08:00:00: alarm wins
    alarm_hour = 5'd8;
    alarm_min  = 6'd0;
    set_time(8, 0, 0);
    do_tick();
    check("coincide_alarm", {ring, snoozing}, O_ALARM);
    press_stop();
    set_time(8, 0, 1);
    ticks(1);
    check("chime_not_queued", {ring, snoozing}, O_IDLE);

    // Alarm pre-empts a running chime and restarts the count
    alarm_en   = 1'b0;
    alarm_hour = 5'd9;
    set_time(9, 0, 0);
    do_tick();
    check("preempt_chime", {ring, snoozing}, O_CHIME);
    ticks(1);
    alarm_en = 1'b1;
    ticks(1);
    check("preempt_alarm", {ring, snoozing}, O_ALARM);
    set_time(9, 0, 1);
    ticks(9);
    check("preempt_cnt_9", {ring, snoozing}, O_ALARM);
    ticks(1);
    check("preempt_expire", {ring, snoozing}, O_IDLE);

    // stop and snooze together in ALARM -> IDLE
    set_time(9, 0, 0);
    do_tick();
    stop_btn   = 1'b1;
    snooze_btn = 1'b1;
    cyc();
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    check("stop_snz_same", {ring, snoozing}, O_IDLE);

    // alarm_en dropped in SNOOZE -> IDLE (snooze count was cleared)
    do_tick();
    press_snooze();
    check("fresh_snooze", {ring, snoozing}, O_SNZ);
    alarm_en = 1'b0;
    cyc();
    alarm_en = 1'b1;
    check("disarm_in_snz", {ring, snoozing}, O_IDLE);

    // stop in SNOOZE -> IDLE
    do_tick();
    press_snooze();
    press_stop();
    check("stop_in_snz", {ring, snoozing}, O_IDLE);

    // Asynchronous reset during ALARM
    do_tick();
    check("pre_reset_alarm", {ring, snoozing}, O_ALARM);
    rst_n = 1'b0;
    #2;
    check("async_reset", {ring, snoozing}, O_IDLE);
    #2;
    rst_n = 1'b1;
    set_time(9, 0, 1);
    ticks(3);
    check("post_reset_quiet", {ring, snoozing}, O_IDLE);
    set_time(9, 0, 0);
    do_tick();
    check("post_reset_trig", {ring, snoozing}, O_ALARM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
